instr_fetch_unit: RTL and testbench

//  Producer side of the instruction interface consumed by the control unit:
//   - fetches 32-bit ARM words from instruction memory over an in-order req/rsp handshake;
//   - buffers them in a prefetch queue;
//   - presents the head instruction as Instr plus pre-split Cond/Op/Funct/Rd fields.

---
 rtl/instr_fetch_unit_pkg.sv | 22 ++
 rtl/instr_fetch_unit_queue.sv | 62 ++++++
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
//   fetch_slot_t : one prefetched word together with the address it was fetched from
//   PC_INC       : sequential fetch stride in bytes
//   PC_AHEAD     : offset of the architectural R15 read value from the head PC
//   *_MSB        : bit positions of the pre-split instruction fields
package instr_fetch_unit_pkg;

  localparam int unsigned IFU_ADDR_W = 32;
  localparam int unsigned PC_INC     = 4;
  localparam int unsigned PC_AHEAD   = 8;

  localparam int unsigned COND_MSB  = 31;
  localparam int unsigned OP_MSB    = 27;
  localparam int unsigned FUNCT_MSB = 25;
  localparam int unsigned RD_MSB    = 15;

  typedef struct packed {
    logic [31:0]           instr;
    logic [IFU_ADDR_W-1:0] pc;
  } fetch_slot_t;

endpackage

// File: rtl/instr_fetch_unit_queue.sv
// fetch_queue: DEPTH-entry FIFO of fetch_slot_t used as the prefetch buffer.
//   clk, rst_i    : clock, asynchronous active-high reset (clears storage too)
//   push_i        : write push_data_i at the tail (caller guarantees not full)
//   pop_i         : retire the head (caller guarantees not empty)
//   flush_i       : discard all entries; overrides push/pop in the same cycle
//   head_o        : current head entry (meaningful only when count_o != 0)
//   count_o       : number of valid entries, 0..DEPTH
module fetch_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  fetch_slot_t              push_data_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  output fetch_slot_t              head_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  fetch_slot_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches ARM words over an in-order req/rsp memory port,
// buffers them in a prefetch queue and presents the head with its fields split.
//   clk, reset          : clock, asynchronous active-high reset
//   imem_req_*          : fetch request (valid/ready handshake, word address)
//   imem_rsp_*          : in-order read data, one word per accepted request
//   instr_valid/ready   : head instruction handshake towards the control unit
//   Instr/Cond/Op/Funct/Rd : head word and its pre-split fields
//   PC, PCPlus8         : head address and head address + 8
//   PCSrc, branch_target: single-cycle redirect strobe and target
// Optional build macro FETCH_STATS_EN adds saturating counters
//   stat_fetched, stat_dropped, stat_stall.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       Instr,
  output logic [3:0]        Cond,
  output logic [1:0]        Op,
  output logic [5:0]        Funct,
  output logic [3:0]        Rd,
  output logic [ADDR_W-1:0] PC,
  output logic [ADDR_W-1:0] PCPlus8,
  input  logic              PCSrc,
  input  logic [ADDR_W-1:0] branch_target
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       stat_fetched,
  output logic [31:0]       stat_dropped,
  output logic [31:0]       stat_stall
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;   // address of the next response that will be kept
  logic [CW-1:0]     outst_q, outst_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     q_count;
  logic [CW-1:0]     in_flight;
  logic [ADDR_W-1:0] target_aligned;
  logic              accept, pop, push, rsp_drop;
  fetch_slot_t       push_slot, head;

  assign target_aligned = {branch_target[ADDR_W-1:2], 2'b00};
  assign in_flight      = q_count + outst_q;

  // A redirect cycle never issues, so accept is already zero when PCSrc is high.
  assign imem_req_valid = !reset && !PCSrc && (in_flight < CW'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign instr_valid = (q_count != '0);
  assign pop         = instr_valid && instr_ready;

  // Responses owed to a stale path, or arriving alongside a redirect, never reach the queue.
  assign rsp_drop = imem_rsp_valid && ((drop_q != '0) || PCSrc);
  assign push     = imem_rsp_valid && !rsp_drop;

  assign push_slot = '{instr: imem_rsp_data, pc: IFU_ADDR_W'(rsp_pc_q)};

  always_comb begin
    outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid);

    drop_d = drop_q;
    if (PCSrc)                                drop_d = outst_d;
    else if (imem_rsp_valid && drop_q != '0)  drop_d = drop_q - CW'(1);

    fetch_pc_d = fetch_pc_q;
    if (PCSrc)       fetch_pc_d = target_aligned;
    else if (accept) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);

    rsp_pc_d = rsp_pc_q;
    if (PCSrc)     rsp_pc_d = target_aligned;
    else if (push) rsp_pc_d = rsp_pc_q + ADDR_W'(PC_INC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q <= {RESET_PC[ADDR_W-1:2], 2'b00};
      rsp_pc_q   <= {RESET_PC[ADDR_W-1:2], 2'b00};
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_i       (reset),
    .push_i      (push),
    .push_data_i (push_slot),
    .pop_i       (pop),
    .flush_i     (PCSrc),
    .head_o      (head),
    .count_o     (q_count)
  );

  assign Instr   = instr_valid ? head.instr : '0;
  assign PC      = instr_valid ? ADDR_W'(head.pc) : '0;
  assign PCPlus8 = PC + ADDR_W'(PC_AHEAD);
  assign Cond    = Instr[COND_MSB  -: 4];
  assign Op      = Instr[OP_MSB    -: 2];
  assign Funct   = Instr[FUNCT_MSB -: 6];
  assign Rd      = Instr[RD_MSB    -: 4];

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, dropped_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetched_q <= '0;
      dropped_q <= '0;
      stall_q   <= '0;
    end else begin
      if (accept && fetched_q != '1)      fetched_q <= fetched_q + 32'd1;
      if (rsp_drop && dropped_q != '1)    dropped_q <= dropped_q + 32'd1;
      if (!instr_valid && stall_q != '1)  stall_q   <= stall_q + 32'd1;
    end
  end

  assign stat_fetched = fetched_q;
  assign stat_dropped = dropped_q;
  assign stat_stall   = stall_q;
`endif

  assert property (@(posedge clk) disable iff (reset) imem_rsp_valid |-> (outst_q != '0));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b1;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [5:0]  Funct;
  logic [3:0]  Rd;
  logic [31:0] PC;
  logic [31:0] PCPlus8;
  logic        PCSrc = 1'b0;
  logic [31:0] branch_target = '0;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched, stat_dropped, stat_stall;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH), .ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .Instr          (Instr),
    .Cond           (Cond),
    .Op             (Op),
    .Funct          (Funct),
    .Rd             (Rd),
    .PC             (PC),
    .PCPlus8        (PCPlus8),
    .PCSrc          (PCSrc),
    .branch_target  (branch_target)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched   (stat_fetched),
    .stat_dropped   (stat_dropped),
    .stat_stall     (stat_stall)
`endif
  );

  int          passed = 0;
  int          total  = 0;
  int          cyc    = 0;
  int          lat    = 1;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] log_pc[$];
  logic [31:0] log_ins[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h10) return 32'hE3A0_1005;
    return {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // One clock cycle: memory answers, handshakes are observed, edge, settle.
  task automatic step();
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    if (instr_valid && instr_ready) begin
      log_pc.push_back(PC);
      log_ins.push_back(Instr);
    end
    if (imem_req_valid && imem_req_ready) begin
      pend_addr.push_back(imem_req_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = '0;
    PCSrc = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    pend_addr.delete(); pend_due.delete();
    log_pc.delete(); log_ins.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL reset_req_valid got %b exp 0", imem_req_valid); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid got %b exp 0", instr_valid); else passed++;
    total++; if (Instr !== 32'h0) $display("FAIL reset_instr got %h exp 00000000", Instr); else passed++;
    total++; if (PC !== 32'h0) $display("FAIL reset_pc got %h exp 00000000", PC); else passed++;
    total++; if (PCPlus8 !== 32'h8) $display("FAIL reset_pcplus8 got %h exp 00000008", PCPlus8); else passed++;
`ifdef FETCH_STATS_EN
    total++; if ({stat_fetched, stat_dropped, stat_stall} !== 96'h0) $display("FAIL reset_stats got %h/%h/%h exp 0", stat_fetched, stat_dropped, stat_stall); else passed++;
`endif
    reset = 1'b0;
    #1;
    total++; if (imem_req_valid !== 1'b1) $display("FAIL release_req_valid got %b exp 1", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 32'h0) $display("FAIL release_req_addr got %h exp 00000000", imem_req_addr); else passed++;
  endtask

  task automatic test_stream();
    logic [31:0] epc;
    do_reset(); lat = 1;
    step();
    total++; if (instr_valid !== 1'b0) $display("FAIL stream_first_valid got %b exp 0", instr_valid); else passed++;
    for (int k = 1; k <= 8; k++) begin
      step();
      epc = 32'(4 * (k - 1));
      total++; if (instr_valid !== 1'b1 || PC !== epc) $display("FAIL stream_pc k=%0d got v=%b %h exp v=1 %h", k, instr_valid, PC, epc); else passed++;
      total++; if (PCPlus8 !== epc + 32'd8) $display("FAIL stream_pcplus8 k=%0d got %h exp %h", k, PCPlus8, epc + 32'd8); else passed++;
      total++; if (Instr !== word(epc)) $display("FAIL stream_instr k=%0d got %h exp %h", k, Instr, word(epc)); else passed++;
      total++; if (imem_req_addr !== 32'(4 * (k + 1))) $display("FAIL stream_req_addr k=%0d got %h exp %h", k, imem_req_addr, 32'(4 * (k + 1))); else passed++;
      if (k == 5) begin
        total++; if ({Cond, Op, Funct, Rd} !== {4'hE, 2'h0, 6'h3A, 4'h1})
          $display("FAIL stream_fields got Cond=%h Op=%h Funct=%h Rd=%h exp E 0 3A 1", Cond, Op, Funct, Rd); else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset(); lat = 1; instr_ready = 1'b0;
    repeat (10) step();
    total++; if (imem_req_valid !== 1'b0) $display("FAIL bp_req_valid got %b exp 0", imem_req_valid); else passed++;
    total++; if (imem_req_addr !== 32'h10) $display("FAIL bp_req_addr got %h exp 00000010", imem_req_addr); else passed++;
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0) $display("FAIL bp_head got v=%b %h exp v=1 00000000", instr_valid, PC); else passed++;
    instr_ready = 1'b1;
    repeat (12) step();
    total++;
    if (log_pc.size() < 8) $display("FAIL bp_drain_count got %0d exp >=8", log_pc.size());
    else begin
      passed++;
      for (int j = 0; j < 8; j++) begin
        total++; if (log_pc[j] !== 32'(4 * j) || log_ins[j] !== word(32'(4 * j)))
          $display("FAIL bp_drain_order j=%0d got %h/%h exp %h/%h", j, log_pc[j], log_ins[j], 32'(4 * j), word(32'(4 * j))); else passed++;
      end
    end
  endtask

  task automatic test_redirect();
    do_reset(); lat = 3;
    step(); step();
    PCSrc = 1'b1; branch_target = 32'h103;
    #1;
    total++; if (imem_req_valid !== 1'b0) $display("FAIL redir_req_forced got %b exp 0", imem_req_valid); else passed++;
    step();
    PCSrc = 1'b0;
    total++; if (imem_req_addr !== 32'h100) $display("FAIL redir_fetch_pc got %h exp 00000100", imem_req_addr); else passed++;
    for (int k = 0; k < 3; k++) begin
      step();
      total++; if (instr_valid !== 1'b0) $display("FAIL redir_drop_valid k=%0d got %b exp 0 (pc %h)", k, instr_valid, PC); else passed++;
    end
    step();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h100 || Instr !== word(32'h100))
      $display("FAIL redir_first got v=%b %h/%h exp v=1 00000100/%h", instr_valid, PC, Instr, word(32'h100)); else passed++;
  endtask

  task automatic test_redirect_pop_rsp();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h200; exp_pc[3] = 32'h204;
    do_reset(); lat = 1;
    repeat (3) step();
    PCSrc = 1'b1; branch_target = 32'h200;
    #1;
    total++; if (instr_valid !== 1'b1 || PC !== 32'h4 || imem_rsp_valid !== 1'b0 || pend_addr.size() != 1)
      $display("FAIL coinc_setup got v=%b pc=%h pend=%0d exp v=1 pc=00000004 pend=1", instr_valid, PC, pend_addr.size()); else passed++;
    step();
    PCSrc = 1'b0;
    total++; if (instr_valid !== 1'b0 || imem_req_addr !== 32'h200) $display("FAIL coinc_after got v=%b addr=%h exp v=0 00000200", instr_valid, imem_req_addr); else passed++;
    step();
    total++; if (instr_valid !== 1'b0) $display("FAIL coinc_stale got v=%b pc=%h exp v=0", instr_valid, PC); else passed++;
    repeat (4) step();
    total++;
    if (log_pc.size() < 4) $display("FAIL coinc_log_count got %0d exp >=4", log_pc.size());
    else begin
      passed++;
      for (int j = 0; j < 4; j++) begin
        total++; if (log_pc[j] !== exp_pc[j]) $display("FAIL coinc_log j=%0d got %h exp %h", j, log_pc[j], exp_pc[j]); else passed++;
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); lat = 3;
    step(); step();
    PCSrc = 1'b1; branch_target = 32'h300; step();
    PCSrc = 1'b1; branch_target = 32'h400; step();
    PCSrc = 1'b0;
    total++; if (imem_req_addr !== 32'h400) $display("FAIL b2b_fetch_pc got %h exp 00000400", imem_req_addr); else passed++;
    repeat (6) step();
    total++;
    if (log_pc.size() < 2) $display("FAIL b2b_log_count got %0d exp >=2", log_pc.size());
    else begin
      passed++;
      total++; if (log_pc[0] !== 32'h400 || log_pc[1] !== 32'h404) $display("FAIL b2b_order got %h,%h exp 00000400,00000404", log_pc[0], log_pc[1]); else passed++;
    end
  endtask

  task automatic test_wrap();
    do_reset(); lat = 1;
    PCSrc = 1'b1; branch_target = 32'hFFFF_FFFF; step();
    PCSrc = 1'b0;
    total++; if (imem_req_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_target got %h exp FFFFFFFC", imem_req_addr); else passed++;
    step();
    total++; if (imem_req_addr !== 32'h0) $display("FAIL wrap_next_addr got %h exp 00000000", imem_req_addr); else passed++;
    step();
    total++; if (instr_valid !== 1'b1 || PC !== 32'hFFFF_FFFC || PCPlus8 !== 32'h4)
      $display("FAIL wrap_head got v=%b %h/%h exp v=1 FFFFFFFC/00000004", instr_valid, PC, PCPlus8); else passed++;
    step();
    total++; if (instr_valid !== 1'b1 || PC !== 32'h0) $display("FAIL wrap_head2 got v=%b %h exp v=1 00000000", instr_valid, PC); else passed++;
  endtask

  task automatic test_async_reset();
    do_reset(); lat = 1;
    repeat (4) step();
    total++; if (instr_valid !== 1'b1) $display("FAIL areset_pre got v=%b exp 1", instr_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0 || imem_req_valid !== 1'b0) $display("FAIL areset_valids got %b/%b exp 0/0", instr_valid, imem_req_valid); else passed++;
    total++; if (Instr !== 32'h0 || PC !== 32'h0 || PCPlus8 !== 32'h8) $display("FAIL areset_outs got %h/%h/%h exp 0/0/8", Instr, PC, PCPlus8); else passed++;
`ifdef FETCH_STATS_EN
    total++; if ({stat_fetched, stat_dropped, stat_stall} !== 96'h0) $display("FAIL areset_stats got %h/%h/%h exp 0", stat_fetched, stat_dropped, stat_stall); else passed++;
`endif
    pend_addr.delete(); pend_due.delete();
    log_pc.delete(); log_ins.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    cyc = 0;
    #1;
    total++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) $display("FAIL areset_first_req got v=%b %h exp v=1 00000000", imem_req_valid, imem_req_addr); else passed++;
    repeat (3) step();
    total++; if (log_pc.size() < 1 || log_pc[0] !== 32'h0) $display("FAIL areset_first_retire got n=%0d exp first pc 00000000", log_pc.size()); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_redirect_pop_rsp();
    test_back_to_back();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached, %0d/%0d so far", passed, total);
    $fatal(1);
  end

endmodule
